writeback_unit: RTL and testbench

//  Write-side driver of the CPU register file: collects ALU results and load data from the data bus,

---
 rtl/writeback_unit_pkg.sv | 23 ++
 rtl/writeback_unit_if.sv | 34 +++
 rtl/writeback_unit_load_align.sv | 43 ++++
 rtl/writeback_unit.sv | 113 +++++++++++
 tb/tb_writeback_unit.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared CPU types for the register-file write-back path: load encodings,
// write-back FSM states and datapath widths.
package writeback_unit_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        LT_LB  = 3'd0,
        LT_LBU = 3'd1,
        LT_LH  = 3'd2,
        LT_LHU = 3'd3,
        LT_LW  = 3'd4,
        LT_LWL = 3'd5,
        LT_LWR = 3'd6
    } load_type_t;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Execute-stage, data-bus and register-file signals of the write-back unit.
// The master side drives instructions and load data; the slave side is the unit.
interface writeback_unit_if;
    import writeback_unit_pkg::*;

    logic              ex_valid;
    logic              ex_reg_write;
    logic [REG_AW-1:0] ex_dest;
    logic [DATA_W-1:0] ex_alu_result;
    logic              ex_is_load;
    logic [2:0]        ex_load_type;
    logic [1:0]        ex_addr_low;
    logic [DATA_W-1:0] ex_rt_old;
    logic              mem_readdata_valid;
    logic [DATA_W-1:0] mem_readdata;
    logic              write_enable;
    logic [REG_AW-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              stall;
    logic              protocol_error;

    modport master (
        output ex_valid, ex_reg_write, ex_dest, ex_alu_result, ex_is_load,
               ex_load_type, ex_addr_low, ex_rt_old, mem_readdata_valid, mem_readdata,
        input  write_enable, write_reg, write_data, stall, protocol_error
    );

    modport slave (
        input  ex_valid, ex_reg_write, ex_dest, ex_alu_result, ex_is_load,
               ex_load_type, ex_addr_low, ex_rt_old, mem_readdata_valid, mem_readdata,
        output write_enable, write_reg, write_data, stall, protocol_error
    );

endinterface

// File: rtl/writeback_unit_load_align.sv
// Combinational load alignment: byte/halfword extraction with sign or zero
// extension, word pass-through and LWL/LWR merging with the old register value.
module load_align
    import writeback_unit_pkg::*;
(
    input  load_type_t        i_load_type,
    input  logic [1:0]        i_addr_low,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_rt_old,
    output logic [DATA_W-1:0] o_data
);

    logic [4:0]        w_byte_sh;
    logic [4:0]        w_lwl_sh;
    logic [DATA_W-1:0] w_shr;
    logic [DATA_W-1:0] w_lwl;
    logic [DATA_W-1:0] w_lwr;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    // LWL shifts by 3-k bytes; for a two-bit k that is simply ~k.
    assign w_byte_sh = {i_addr_low, 3'b000};
    assign w_lwl_sh  = {~i_addr_low, 3'b000};
    assign w_shr     = i_mem_data >> w_byte_sh;
    assign w_byte    = w_shr[7:0];
    assign w_half    = i_addr_low[1] ? i_mem_data[31:16] : i_mem_data[15:0];
    assign w_lwl     = (i_mem_data << w_lwl_sh) | (i_rt_old & ~({DATA_W{1'b1}} << w_lwl_sh));
    assign w_lwr     = w_shr | (i_rt_old & ~({DATA_W{1'b1}} >> w_byte_sh));

    always_comb begin
        o_data = i_mem_data;
        case (i_load_type)
            LT_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            LT_LBU:  o_data = {24'd0, w_byte};
            LT_LH:   o_data = {{16{w_half[15]}}, w_half};
            LT_LHU:  o_data = {16'd0, w_half};
            LT_LWL:  o_data = w_lwl;
            LT_LWR:  o_data = w_lwr;
            default: o_data = i_mem_data;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write-back driver: one registered write per cycle from ALU
// results or aligned load data, stalling upstream while a load is outstanding.
module writeback_unit
    import writeback_unit_pkg::*;
(
    input logic            clk,
    input logic            reset,
    writeback_unit_if.slave wb
);

    wb_state_t         r_state;
    wb_state_t         w_next_state;

    logic [REG_AW-1:0] r_dest;
    load_type_t        r_load_type;
    logic [1:0]        r_addr_low;
    logic [DATA_W-1:0] r_rt_old;
    logic              r_reg_write;

    logic              r_write_enable;
    logic [REG_AW-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;
    logic              r_stall;
    logic              r_protocol_error;

    logic              w_write_enable;
    logic [REG_AW-1:0] w_write_reg;
    logic [DATA_W-1:0] w_write_data;
    logic              w_protocol_error;
    logic              w_latch;
    logic [DATA_W-1:0] w_aligned;

    load_align u_load_align (
        .i_load_type (r_load_type),
        .i_addr_low  (r_addr_low),
        .i_mem_data  (wb.mem_readdata),
        .i_rt_old    (r_rt_old),
        .o_data      (w_aligned)
    );

    always_comb begin
        w_next_state     = r_state;
        w_write_enable   = 1'b0;
        w_write_reg      = r_write_reg;
        w_write_data     = r_write_data;
        w_protocol_error = r_protocol_error;
        w_latch          = 1'b0;
        case (r_state)
            IDLE: begin
                if (wb.mem_readdata_valid) begin
                    w_protocol_error = 1'b1;
                end
                if (wb.ex_valid && wb.ex_is_load) begin
                    w_latch      = 1'b1;
                    w_next_state = WAIT_LOAD;
                end else if (wb.ex_valid && wb.ex_reg_write) begin
                    w_write_enable = (wb.ex_dest != '0);
                    w_write_reg    = wb.ex_dest;
                    w_write_data   = wb.ex_alu_result;
                end
            end
            WAIT_LOAD: begin
                // New instructions are held off by stall, so ex_valid is ignored here.
                if (wb.mem_readdata_valid) begin
                    w_next_state = IDLE;
                    if (r_reg_write) begin
                        w_write_enable = (r_dest != '0);
                        w_write_reg    = r_dest;
                        w_write_data   = w_aligned;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_dest           <= '0;
            r_load_type      <= LT_LW;
            r_addr_low       <= '0;
            r_rt_old         <= '0;
            r_reg_write      <= 1'b0;
            r_write_enable   <= 1'b0;
            r_write_reg      <= '0;
            r_write_data     <= '0;
            r_stall          <= 1'b0;
            r_protocol_error <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_write_enable   <= w_write_enable;
            r_write_reg      <= w_write_reg;
            r_write_data     <= w_write_data;
            r_stall          <= (w_next_state == WAIT_LOAD);
            r_protocol_error <= w_protocol_error;
            if (w_latch) begin
                r_dest      <= wb.ex_dest;
                r_load_type <= load_type_t'(wb.ex_load_type);
                r_addr_low  <= wb.ex_addr_low;
                r_rt_old    <= wb.ex_rt_old;
                r_reg_write <= wb.ex_reg_write;
            end
        end
    end

    assign wb.write_enable   = r_write_enable;
    assign wb.write_reg      = r_write_reg;
    assign wb.write_data     = r_write_data;
    assign wb.stall          = r_stall;
    assign wb.protocol_error = r_protocol_error;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU writes, every load flavour, register 0,
// protocol errors and reset during an outstanding load.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    writeback_unit_if bus ();

    writeback_unit dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic regWrite, input logic isLoad,
                                 input logic [2:0] loadType, input logic [1:0] addrLow,
                                 input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] rtOld);
        bus.ex_valid      = valid;
        bus.ex_reg_write  = regWrite;
        bus.ex_is_load    = isLoad;
        bus.ex_load_type  = loadType;
        bus.ex_addr_low   = addrLow;
        bus.ex_dest       = dest;
        bus.ex_alu_result = alu;
        bus.ex_rt_old     = rtOld;
    endtask

    task automatic clearStimulus();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 32'd0, 32'd0);
        bus.mem_readdata_valid = 1'b0;
        bus.mem_readdata       = 32'd0;
    endtask

    // Issue a load, answer it waitCycles cycles later, and check stall and the write.
    // A competing ALU op is driven during the wait to show it is ignored.
    task automatic doLoad(input string tag, input logic [2:0] loadType, input logic [1:0] addrLow,
                          input logic [4:0] dest, input logic [31:0] rtOld, input logic [31:0] mem,
                          input int waitCycles, input logic [31:0] expData);
        applyStimulus(1'b1, 1'b1, 1'b1, loadType, addrLow, dest, 32'h0BAD_0BAD, rtOld);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd9, 32'h9999_9999, 32'd0);
        for (int i = 0; i < waitCycles; i++) begin
            checkOutput({tag, " stall"}, {31'd0, bus.stall}, 32'd1);
            checkOutput({tag, " we during wait"}, {31'd0, bus.write_enable}, 32'd0);
            if (i == waitCycles - 1) begin
                bus.mem_readdata_valid = 1'b1;
                bus.mem_readdata       = mem;
            end
            tick();
        end
        clearStimulus();
        checkOutput({tag, " we"}, {31'd0, bus.write_enable}, {31'd0, dest != 5'd0});
        checkOutput({tag, " reg"}, {27'd0, bus.write_reg}, {27'd0, dest});
        checkOutput({tag, " data"}, bus.write_data, expData);
        checkOutput({tag, " stall released"}, {31'd0, bus.stall}, 32'd0);
        tick();
        checkOutput({tag, " we after"}, {31'd0, bus.write_enable}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clearStimulus();
        reset = 1'b1;
        tick();
        tick();
        checkOutput("reset we", {31'd0, bus.write_enable}, 32'd0);
        checkOutput("reset reg", {27'd0, bus.write_reg}, 32'd0);
        checkOutput("reset data", bus.write_data, 32'd0);
        checkOutput("reset stall", {31'd0, bus.stall}, 32'd0);
        checkOutput("reset perr", {31'd0, bus.protocol_error}, 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] ALU write");
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd3, 32'h1234_5678, 32'd0);
        tick();
        clearStimulus();
        checkOutput("alu we", {31'd0, bus.write_enable}, 32'd1);
        checkOutput("alu reg", {27'd0, bus.write_reg}, 32'd3);
        checkOutput("alu data", bus.write_data, 32'h1234_5678);
        tick();
        checkOutput("alu we drop", {31'd0, bus.write_enable}, 32'd0);

        $display("[TB] byte/halfword loads");
        doLoad("LB k2",  3'd0, 2'd2, 5'd4, 32'd0, 32'h4480_FF11, 3, 32'hFFFF_FF80);
        doLoad("LBU k2", 3'd1, 2'd2, 5'd5, 32'd0, 32'h4480_FF11, 3, 32'h0000_0080);
        doLoad("LH a2",  3'd2, 2'd2, 5'd6, 32'd0, 32'h4480_FF11, 2, 32'h0000_4480);
        doLoad("LHU a0", 3'd3, 2'd0, 5'd7, 32'd0, 32'h4480_FF11, 1, 32'h0000_FF11);
        doLoad("LH a1",  3'd2, 2'd1, 5'd8, 32'd0, 32'h4480_FF11, 1, 32'hFFFF_FF11);
        doLoad("LW t7",  3'd7, 2'd0, 5'd10, 32'd0, 32'h4480_FF11, 1, 32'h4480_FF11);

        $display("[TB] LWL/LWR merges");
        doLoad("LWL k1", 3'd5, 2'd1, 5'd11, 32'hAABB_CCDD, 32'h4433_2211, 1, 32'h2211_CCDD);
        doLoad("LWR k1", 3'd6, 2'd1, 5'd12, 32'hAABB_CCDD, 32'h4433_2211, 2, 32'hAA44_3322);
        doLoad("LWL k3", 3'd5, 2'd3, 5'd13, 32'hAABB_CCDD, 32'h4433_2211, 1, 32'h4433_2211);
        doLoad("LWR k0", 3'd6, 2'd0, 5'd14, 32'hAABB_CCDD, 32'h4433_2211, 1, 32'h4433_2211);

        $display("[TB] destination zero");
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd0, 32'hDEAD_BEEF, 32'd0);
        tick();
        clearStimulus();
        checkOutput("r0 alu we", {31'd0, bus.write_enable}, 32'd0);
        checkOutput("r0 alu data", bus.write_data, 32'hDEAD_BEEF);
        tick();
        doLoad("r0 LW", 3'd4, 2'd0, 5'd0, 32'd0, 32'h5555_AAAA, 2, 32'h5555_AAAA);

        $display("[TB] response while idle");
        checkOutput("perr before", {31'd0, bus.protocol_error}, 32'd0);
        bus.mem_readdata_valid = 1'b1;
        bus.mem_readdata       = 32'h7777_7777;
        tick();
        clearStimulus();
        checkOutput("idle resp we", {31'd0, bus.write_enable}, 32'd0);
        checkOutput("idle resp perr", {31'd0, bus.protocol_error}, 32'd1);
        tick();
        tick();
        checkOutput("perr sticky", {31'd0, bus.protocol_error}, 32'd1);

        $display("[TB] reset during outstanding load");
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd4, 2'd0, 5'd15, 32'd0, 32'd0);
        tick();
        clearStimulus();
        checkOutput("abandon stall", {31'd0, bus.stall}, 32'd1);
        tick();
        reset = 1'b1;
        bus.mem_readdata_valid = 1'b1;
        bus.mem_readdata       = 32'h1111_2222;
        tick();
        reset = 1'b0;
        clearStimulus();
        checkOutput("abandon we", {31'd0, bus.write_enable}, 32'd0);
        checkOutput("abandon reg", {27'd0, bus.write_reg}, 32'd0);
        checkOutput("abandon data", bus.write_data, 32'd0);
        checkOutput("abandon stall clr", {31'd0, bus.stall}, 32'd0);
        checkOutput("abandon perr clr", {31'd0, bus.protocol_error}, 32'd0);
        tick();
        checkOutput("abandon no write", {31'd0, bus.write_enable}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd5, 32'hCAFE_F00D, 32'd0);
        tick();
        clearStimulus();
        checkOutput("post reset we", {31'd0, bus.write_enable}, 32'd1);
        checkOutput("post reset reg", {27'd0, bus.write_reg}, 32'd5);
        checkOutput("post reset data", bus.write_data, 32'hCAFE_F00D);
        bus.mem_readdata_valid = 1'b1;
        bus.mem_readdata       = 32'h3333_4444;
        tick();
        clearStimulus();
        checkOutput("late resp we", {31'd0, bus.write_enable}, 32'd0);
        checkOutput("late resp perr", {31'd0, bus.protocol_error}, 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
